// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the M-extension divide group
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [XLEN_DEF-1:0] DIV0_QUOT = '1;
  localparam logic [XLEN_DEF-1:0] OVF_QUOT  = {1'b1, {(XLEN_DEF-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - single radix-2 restoring divide iteration (combinational)
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] quo_sh;

  // rem < divisor always holds, so the shifted value fits XLEN+1 bits and
  // the top bit of the difference is a reliable borrow flag.
  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    quo_sh = {quo[XLEN-2:0], 1'b0};
    diff   = rem_sh - {1'b0, divisor};
    if (diff[XLEN]) begin
      rem_next = rem_sh[XLEN-1:0];
      quo_next = quo_sh;
    end else begin
      rem_next = diff[XLEN-1:0];
      quo_next = {quo_sh[XLEN-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle DIV/DIVU/REM/REMU controller for the execute stage
module div_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0]  ALL_ONES = '1;
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  div_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] quo, rem, dvs;
  logic [XLEN-1:0] quo_n, rem_n;
  logic            sel_rem, neg_quo, neg_rem;
  logic            done_q;

  logic            go;
  logic            is_signed, a_neg, b_neg;
  logic            div_zero, overflow;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] quo_fix, rem_fix;

  // funct3[2] marks the divide half of the M group; anything else never starts.
  always_comb begin
    go        = start & ~flush & funct3[2];
    is_signed = ~funct3[0];
    a_neg     = is_signed & op_a[XLEN-1];
    b_neg     = is_signed & op_b[XLEN-1];
    div_zero  = (op_b == '0);
    overflow  = is_signed & (op_a == MIN_NEG) & (op_b == ALL_ONES);
    mag_a     = a_neg ? (~op_a + 1'b1) : op_a;
    mag_b     = b_neg ? (~op_b + 1'b1) : op_b;
    quo_fix   = neg_quo ? (~quo_n + 1'b1) : quo_n;
    rem_fix   = neg_rem ? (~rem_n + 1'b1) : rem_n;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (rem_n),
    .quo_next (quo_n)
  );

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          stall     = 1'b1;
          state_nxt = (div_zero | overflow) ? DONE : RUN;
        end
      end
      RUN: begin
        stall = 1'b1;
        if (flush)           state_nxt = IDLE;
        else if (cnt == '0)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Special cases write their final value directly; normal ops are sign-fixed
  // on the last iteration so the registered result is visible in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      sel_rem <= 1'b0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      done_q  <= 1'b0;
      result  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            sel_rem <= funct3[1];
            neg_quo <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            if (div_zero) begin
              result <= funct3[1] ? op_a : ALL_ONES;
              done_q <= 1'b1;
            end else if (overflow) begin
              result <= funct3[1] ? '0 : MIN_NEG;
              done_q <= 1'b1;
            end else begin
              quo <= mag_a;
              rem <= '0;
              dvs <= mag_b;
              cnt <= CNT_LAST;
            end
          end
        end
        RUN: begin
          if (!flush) begin
            quo <= quo_n;
            rem <= rem_n;
            if (cnt == '0) begin
              result <= sel_rem ? rem_fix : quo_fix;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign done = done_q & ~flush;

endmodule
